// File: rtl/omem_writeback_ctrl.sv
// Drains the output buffer into output memory: linear buffer reads, strided
// 2-D memory write addresses, one-cycle read-to-write pipeline.
module omem_writeback_ctrl #(
   parameter int OBAW = 12,
   parameter int OAW  = 19,
   parameter int CW   = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [OAW-1:0]  base_addr,
   input  logic [CW-1:0]   row_len,
   input  logic [CW-1:0]   num_rows,
   input  logic [OAW-1:0]  row_stride,
   input  logic            pause,
   output logic            obuf_rd_en,
   output logic [OBAW-1:0] obuf_rd_addr,
   output logic [31:0]     omem_addr,
   output logic            omem_wr_en,
   output logic            busy,
   output logic            done,
   output logic            cfg_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   row_len_q;
   logic [CW-1:0]   num_rows_q;
   logic [OAW-1:0]  stride_q;
   logic [CW-1:0]   col;
   logic [CW-1:0]   row;
   logic [OAW-1:0]  row_base;
   logic [OAW-1:0]  pend_addr;
   logic [OBAW-1:0] rd_idx;
   logic            err_q;

   // Word count only gates acceptance; address generation stays multiplier-free.
   logic [31:0] n_words;
   logic        too_big;
   assign n_words = 32'(row_len) * 32'(num_rows);
   assign too_big = n_words > (32'd1 << OBAW);

   // NOTE: every register, outputs included, is cleared by the async reset and
   // assigned with <= so all updates within an edge see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         row_len_q    <= '0;
         num_rows_q   <= '0;
         stride_q     <= '0;
         col          <= '0;
         row          <= '0;
         row_base     <= '0;
         pend_addr    <= '0;
         rd_idx       <= '0;
         err_q        <= 1'b0;
         obuf_rd_en   <= 1'b0;
         obuf_rd_addr <= '0;
         omem_addr    <= '0;
         omem_wr_en   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         obuf_rd_en <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         // Buffer data arrives one cycle after the read, so the write trails it.
         omem_wr_en <= obuf_rd_en;
         omem_addr  <= 32'(pend_addr);

         case (state)
            IDLE: begin
               // A start coinciding with the done pulse must be reasserted later.
               if (start && !done) begin
                  row_len_q  <= row_len;
                  num_rows_q <= num_rows;
                  stride_q   <= row_stride;
                  row_base   <= base_addr;
                  col        <= '0;
                  row        <= '0;
                  rd_idx     <= '0;
                  if (row_len == '0 || num_rows == '0) begin
                     err_q <= 1'b0;
                     state <= DONE;
                  end else if (too_big) begin
                     err_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     err_q <= 1'b0;
                     busy  <= 1'b1;
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (!pause) begin
                  obuf_rd_en   <= 1'b1;
                  obuf_rd_addr <= rd_idx;
                  pend_addr    <= row_base + OAW'(col);
                  rd_idx       <= rd_idx + 1'b1;
                  if (col == row_len_q - 1'b1) begin
                     col      <= '0;
                     row      <= row + 1'b1;
                     row_base <= row_base + stride_q;
                     if (row == num_rows_q - 1'b1) state <= FLUSH;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end

            FLUSH: state <= DONE;

            DONE: begin
               done    <= 1'b1;
               cfg_err <= err_q;
               busy    <= 1'b0;
               state   <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
